// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: pipelined rotate / logical / arithmetic barrel shifter.
// Stage s shifts by 2^s when amount bit s is set. All stages move together on
// one global advance enable. Empty slots travel the pipe as bubbles, and the
// last stage drives the output directly.
module barrel_shifter_pipe #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 16,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic             in_dir,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNTW-1:0]  xfer_cnt
);

  // The whole pipe moves whenever the output slot is empty or is being taken.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
    localparam int K = 1 << gi;
    // Ones in the top K positions: the fill pattern for a negative arithmetic right shift.
    localparam logic [WIDTH-1:0] FILL_R = ~({WIDTH{1'b1}} >> K);

    // src_amt[0] is amount bit gi. The higher bits are passed to later stages.
    logic [WIDTH-1:0]  src_data;
    logic [SHW-gi-1:0] src_amt;
    logic              src_dir;
    logic [1:0]        src_mode;
    logic              src_sign;
    logic              src_valid;
    logic [WIDTH-1:0]  shifted;
    logic [WIDTH-1:0]  data_reg;
    logic              valid_reg;

    if (gi == 0) begin : g_head
      assign src_data  = in_data;
      assign src_amt   = in_amt;
      assign src_dir   = in_dir;
      assign src_mode  = in_mode;
      assign src_sign  = in_data[WIDTH-1];
      assign src_valid = in_valid && in_ready;
    end else begin : g_link
      assign src_data  = g_stage[gi-1].data_reg;
      assign src_amt   = g_stage[gi-1].g_side.amt_reg;
      assign src_dir   = g_stage[gi-1].g_side.dir_reg;
      assign src_mode  = g_stage[gi-1].g_side.mode_reg;
      assign src_sign  = g_stage[gi-1].g_side.sign_reg;
      assign src_valid = g_stage[gi-1].valid_reg;
    end

    // Apply this stage's fixed 2^gi shift when its amount bit is set. Mode 11 passes data through.
    always_comb begin
      shifted = src_data;
      if (src_amt[0]) begin
        case (src_mode)
          2'b00:   shifted = src_dir ? ((src_data << K) | (src_data >> (WIDTH - K)))
                                     : ((src_data >> K) | (src_data << (WIDTH - K)));
          2'b01:   shifted = src_dir ? (src_data << K) : (src_data >> K);
          2'b10:   shifted = src_dir ? (src_data << K)
                                     : ((src_data >> K) | (src_sign ? FILL_R : '0));
          default: shifted = src_data;
        endcase
      end
    end

    // Data and valid for this slot. A bubble advances exactly like a word.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_reg  <= '0;
        valid_reg <= 1'b0;
      end else if (adv) begin
        data_reg  <= shifted;
        valid_reg <= src_valid;
      end
    end

    // Sideband for later stages. The last stage has no consumer, so it keeps none.
    if (gi < SHW - 1) begin : g_side
      logic [SHW-gi-2:0] amt_reg;
      logic              dir_reg;
      logic [1:0]        mode_reg;
      logic              sign_reg;

      // Carry the remaining amount bits, direction, mode and original sign one stage on.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          amt_reg  <= '0;
          dir_reg  <= 1'b0;
          mode_reg <= 2'b00;
          sign_reg <= 1'b0;
        end else if (adv) begin
          amt_reg  <= src_amt[SHW-gi-1:1];
          dir_reg  <= src_dir;
          mode_reg <= src_mode;
          sign_reg <= src_sign;
        end
      end
    end
  end

  assign out_valid = g_stage[SHW-1].valid_reg;
  assign out_data  = g_stage[SHW-1].data_reg;

  // Count completed output handshakes. The counter wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (out_valid && out_ready) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Testbench for barrel_shifter_pipe. It has an 8-bit instance and a 32-bit
// instance with CNTW=4. Expected results are queued when a word is accepted,
// and monitors pop them when the DUT transfers an output.
module tb_barrel_shifter_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance signals
  logic        rst_n8 = 1'b1;
  logic        in_valid8, in_ready8, in_dir8, out_valid8, out_ready8;
  logic [7:0]  in_data8, out_data8;
  logic [2:0]  in_amt8;
  logic [1:0]  in_mode8;
  logic [15:0] xfer_cnt8;

  // 32-bit instance signals
  logic        rst_n32 = 1'b1;
  logic        in_valid32, in_ready32, in_dir32, out_valid32, out_ready32;
  logic [31:0] in_data32, out_data32;
  logic [4:0]  in_amt32;
  logic [1:0]  in_mode32;
  logic [3:0]  xfer_cnt32;

  barrel_shifter_pipe #(.WIDTH(8), .CNTW(16)) dut8 (
    .clk(clk), .rst_n(rst_n8), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data8), .in_amt(in_amt8), .in_dir(in_dir8), .in_mode(in_mode8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .xfer_cnt(xfer_cnt8)
  );

  barrel_shifter_pipe #(.WIDTH(32), .CNTW(4)) dut32 (
    .clk(clk), .rst_n(rst_n32), .in_valid(in_valid32), .in_ready(in_ready32),
    .in_data(in_data32), .in_amt(in_amt32), .in_dir(in_dir32), .in_mode(in_mode32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_data(out_data32),
    .xfer_cnt(xfer_cnt32)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int pop8 = 0;
  int last_pop_cyc = -10;
  int streak8 = 0;
  logic [31:0] q8[$];
  logic [31:0] q32[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: an operation on a w-bit word, computed with plain arithmetic.
  function automatic logic [31:0] model(input logic [31:0] d_in, input int amt,
                                        input logic dir, input logic [1:0] mode, input int w);
    logic [63:0] dd;
    logic [31:0] mask, d, r;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    d    = d_in & mask;
    dd   = ({32'd0, d} << w) | {32'd0, d};
    case (mode)
      2'd0:    r = dir ? (32'((dd << amt) >> w) & mask) : (32'(dd >> amt) & mask);
      2'd1:    r = dir ? ((d << amt) & mask) : (d >> amt);
      2'd2:    r = dir ? ((d << amt) & mask)
                       : ((d >> amt) | (d[w-1] ? (mask & ~(mask >> amt)) : 32'd0));
      default: r = d;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: a transfer is committed at the next rising edge, so sample on the falling edge.
  always @(negedge clk) begin
    if (rst_n8 && out_valid8 && out_ready8) begin
      if (q8.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL out8_unexpected: got 0x%0h, expected no word", out_data8);
      end else begin
        check("out8_data", {24'd0, out_data8}, q8.pop_front());
      end
      pop8++;
      streak8 = (cyc == last_pop_cyc + 1) ? streak8 + 1 : 1;
      last_pop_cyc = cyc;
    end
  end

  always @(negedge clk) begin
    if (rst_n32 && out_valid32 && out_ready32) begin
      if (q32.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL out32_unexpected: got 0x%0h, expected no word", out_data32);
      end else begin
        check("out32_data", out_data32, q32.pop_front());
      end
    end
  end

  task automatic send8(input logic [7:0] d, input logic [2:0] a, input logic dir,
                       input logic [1:0] m, input logic use_exp, input logic [7:0] exp_v);
    logic accepted;
    accepted = 1'b0;
    in_data8 = d; in_amt8 = a; in_dir8 = dir; in_mode8 = m; in_valid8 = 1'b1;
    for (int i = 0; i < 64 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready8) begin
        accepted = 1'b1;
        q8.push_back(use_exp ? {24'd0, exp_v} : model({24'd0, d}, int'(a), dir, m, 8));
      end
      @(posedge clk);
      #1;
    end
    in_valid8 = 1'b0;
    if (!accepted) begin
      n_vec++;
      n_bad++;
      $display("FAIL send8_accept: got no in_ready, expected acceptance within 64 cycles");
    end
  endtask

  task automatic send32(input logic [31:0] d, input logic [4:0] a, input logic dir,
                        input logic [1:0] m, input logic use_exp, input logic [31:0] exp_v);
    logic accepted;
    accepted = 1'b0;
    in_data32 = d; in_amt32 = a; in_dir32 = dir; in_mode32 = m; in_valid32 = 1'b1;
    for (int i = 0; i < 64 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready32) begin
        accepted = 1'b1;
        q32.push_back(use_exp ? exp_v : model(d, int'(a), dir, m, 32));
      end
      @(posedge clk);
      #1;
    end
    in_valid32 = 1'b0;
    if (!accepted) begin
      n_vec++;
      n_bad++;
      $display("FAIL send32_accept: got no in_ready, expected acceptance within 64 cycles");
    end
  endtask

  task automatic rand8();
    send8(8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)), 1'b0, 8'h00);
  endtask

  task automatic drain8();
    for (int i = 0; i < 300 && q8.size() != 0; i++) @(posedge clk);
    #1;
    check("drain8_left", q8.size(), 0);
  endtask

  task automatic drain32();
    for (int i = 0; i < 300 && q32.size() != 0; i++) @(posedge clk);
    #1;
    check("drain32_left", q32.size(), 0);
  endtask

  task automatic reset8();
    @(posedge clk);
    #2 rst_n8 = 1'b0;
    q8.delete();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n8 = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected completion before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    logic done;
    in_valid8 = 0; in_data8 = 0; in_amt8 = 0; in_dir8 = 0; in_mode8 = 0; out_ready8 = 1;
    in_valid32 = 0; in_data32 = 0; in_amt32 = 0; in_dir32 = 0; in_mode32 = 0; out_ready32 = 1;

    // Reset state, with no clock edge needed
    #1 rst_n8 = 1'b0; rst_n32 = 1'b0;
    #1;
    check("rst_out_valid", out_valid8, 0);
    check("rst_out_data", out_data8, 0);
    check("rst_xfer_cnt", xfer_cnt8, 0);
    check("rst_in_ready", in_ready8, 1);
    check("rst32_out_valid", out_valid32, 0);
    repeat (2) @(posedge clk);
    #2 rst_n8 = 1'b1; rst_n32 = 1'b1;
    @(posedge clk);
    #1;

    // Latency: accepted at E0, out_valid appears after E0+2
    send8(8'h81, 3'd1, 1'b0, 2'd0, 1'b1, 8'hC0);
    @(negedge clk) check("lat_after_e0", out_valid8, 0);
    @(negedge clk) check("lat_after_e1", out_valid8, 0);
    @(negedge clk) check("lat_after_e2", out_valid8, 1);
    @(posedge clk);
    #1;

    // Directed 8-bit vectors with hand-derived results
    send8(8'h81, 3'd3, 1'b1, 2'd0, 1'b1, 8'h0C);
    send8(8'hA5, 3'd0, 1'b0, 2'd0, 1'b1, 8'hA5);
    send8(8'h81, 3'd5, 1'b0, 2'd0, 1'b1, 8'h0C);
    send8(8'hF0, 3'd4, 1'b0, 2'd1, 1'b1, 8'h0F);
    send8(8'h80, 3'd2, 1'b0, 2'd2, 1'b1, 8'hE0);
    send8(8'h40, 3'd7, 1'b0, 2'd2, 1'b1, 8'h00);
    send8(8'h80, 3'd7, 1'b0, 2'd2, 1'b1, 8'hFF);
    send8(8'h81, 3'd7, 1'b1, 2'd1, 1'b1, 8'h80);
    send8(8'h81, 3'd1, 1'b1, 2'd2, 1'b1, 8'h02);
    send8(8'h3C, 3'd5, 1'b0, 2'd3, 1'b1, 8'h3C);
    send8(8'h3C, 3'd5, 1'b1, 2'd3, 1'b1, 8'h3C);
    drain8();

    // Random words under random backpressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 64; i++) rand8();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready8 = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready8 = 1'b1;
    drain8();

    // Backpressure: fill the pipe, then stall for 5 cycles with a pending word
    p0 = pop8;
    out_ready8 = 1'b0;
    rand8();
    rand8();
    rand8();
    in_data8 = 8'h96; in_amt8 = 3'd3; in_dir8 = 1'b0; in_mode8 = 2'd2; in_valid8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready8, 0);
      check("bp_out_valid", out_valid8, 1);
      check("bp_out_data", {24'd0, out_data8}, (q8.size() != 0) ? q8[0] : 32'hDEAD);
      @(posedge clk);
      #1;
    end
    out_ready8 = 1'b1;
    send8(8'h96, 3'd3, 1'b0, 2'd2, 1'b1, 8'hF2);
    drain8();
    check("bp_pop_count", pop8 - p0, 4);

    // Reset with three words in flight
    out_ready8 = 1'b1;
    rand8();
    rand8();
    rand8();
    #1 rst_n8 = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid8, 0);
    check("mid_rst_xfer_cnt", xfer_cnt8, 0);
    check("mid_rst_in_ready", in_ready8, 1);
    check("mid_rst_out_data", out_data8, 0);
    q8.delete();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n8 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) check("mid_rst_no_stale", out_valid8, 0);
    end
    @(posedge clk);
    #1;
    send8(8'h0F, 3'd2, 1'b1, 2'd0, 1'b1, 8'h3C);
    drain8();

    // Streaming: 256 back-to-back words from a clean counter
    reset8();
    p0 = pop8;
    out_ready8 = 1'b1;
    for (int i = 0; i < 256; i++) rand8();
    drain8();
    check("stream_pop_count", pop8 - p0, 256);
    check("stream_streak", streak8, 256);
    check("stream_xfer_cnt", xfer_cnt8, 256);

    // 32-bit instance: directed vectors, random fill, then 17 transfers wrap CNTW=4 to 1
    send32(32'h8000_0000, 5'd31, 1'b0, 2'd2, 1'b1, 32'hFFFF_FFFF);
    send32(32'h1234_5678, 5'd16, 1'b1, 2'd0, 1'b1, 32'h5678_1234);
    for (int i = 0; i < 15; i++) begin
      send32($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 1'b0, 32'd0);
    end
    drain32();
    check("xfer32_wrap", xfer_cnt32, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/barrel_shifter_pipe.md
# barrel_shifter_pipe

Parametrised, pipelined barrel shifter with valid/ready flow control on both sides. It supports rotate, logical shift and arithmetic shift in either direction on a WIDTH-bit word, using one register stage per shift-amount bit. It is the streaming successor to the team's 8-bit combinational cyclic shifter and sits between a producer and a consumer that both use valid/ready.

## Interface
- WIDTH, 8: data width; must be a power of two, at least 2.
- SHW, $clog2(WIDTH): shift-amount width and pipeline depth; derived, never overridden.
- CNTW, 16: width of the completed-transfer counter.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block accepts the word this cycle.
- in_data  in  WIDTH  operand.
- in_amt  in  SHW  shift amount, 0..WIDTH-1.
- in_dir  in  1  0 = right, 1 = left.
- in_mode  in  2  00 rotate, 01 logical, 10 arithmetic, 11 reserved.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_data  out  WIDTH  shifted result.
- xfer_cnt  out  CNTW  number of completed output transfers, mod 2^CNTW.

## Operation
- The pipeline has SHW stages. Stage s (0-based) applies a shift of 2^s when in_amt bit s = 1; otherwise it passes data unchanged.
- Each stage registers the following: data, the remaining amount bits, dir, mode, and a valid bit.
- Rotate: bits leaving one end enter the other end, matching the legacy cyclic behaviour.
- Logical: vacated bits are filled with 0.
- Arithmetic right: vacated bits are filled with the original MSB (in_data[WIDTH-1]), carried down the pipe as a sign bit.
- Arithmetic left is identical to logical left.
- Mode 11: data passes unshifted regardless of in_amt and dir. The word is still transferred and still counted.
- in_amt = 0 passes data unchanged in every mode.
- Flow control uses one global advance enable: adv = !out_valid || out_ready.
  - in_ready = adv.
  - On adv, every stage loads from its predecessor.
  - Stage 0 loads in_valid && in_ready, together with the inputs.
- Bubbles are not collapsed: an empty slot travels the pipe like data.
- When adv = 0, all stages hold, and out_data and out_valid stay stable.
- xfer_cnt increments on every edge where out_valid && out_ready. It wraps from 2^CNTW-1 to 0.
- Reset (asynchronous assert, synchronous-safe release) sets:
  - all stage valid bits = 0;
  - out_valid = 0, out_data = 0, xfer_cnt = 0;
  - in_ready = 1 (follows from out_valid = 0).
- In-flight words are discarded on reset and are never emitted.

## Timing
- Latency: a word accepted at edge E0 drives out_valid = 1 after edge E0 + (SHW-1). For WIDTH = 8 this is the third edge counting E0.
- Throughput: one word per cycle while out_ready = 1.
- in_ready depends combinationally on out_ready. There is no other combinational input-to-output path. out_data and out_valid come straight from registers.
- Simultaneous output transfer and new input acceptance in the same cycle is legal and required for full throughput.
- When out_ready is low with out_valid high, the block accepts no input and the producer's word must be held.

## Test plan
- WIDTH=8, rotate:
  - 0x81 right by 1 -> 0xC0.
  - 0x81 left by 3 -> 0x0C.
  - 0xA5 right by 0 -> 0xA5.
  - Result appears with out_valid after 3 edges.
- WIDTH=8, logical and arithmetic:
  - 0xF0 logical right by 4 -> 0x0F.
  - 0x80 arithmetic right by 2 -> 0xE0.
  - 0x40 arithmetic right by 7 -> 0x00.
  - 0x81 logical left by 7 -> 0x80.
  - Mode 11 with 0x3C, amount 5 -> 0x3C.
- Streaming: 256 back-to-back random words with out_ready = 1 -> one result per cycle, in order, all matching the reference model, and xfer_cnt = 256.
- Backpressure: fill the pipe, then hold out_ready = 0 for 5 cycles -> in_ready = 0, and out_data and out_valid are unchanged. After release, all words drain in order with none lost or duplicated.
- Reset mid-flight: assert rst_n = 0 with 3 words in the pipe -> out_valid drops immediately with no clock edge needed, xfer_cnt = 0, and no stale word appears after release.
- WIDTH=32 and xfer_cnt wrap:
  - 0x80000000 arithmetic right by 31 -> 0xFFFFFFFF.
  - Rotate left by 16 of 0x12345678 -> 0x56781234.
  - With CNTW=4, 17 transfers -> xfer_cnt = 1.
